// File: rtl/core_sim_pkg.sv
// core_sim_pkg: types shared by the bring-up controller and its IRQ channels.
//   state_t  - controller FSM states (HOLD, RUN, DONE)
//   status_t - end-of-run codes reported on sim_status
package core_sim_pkg;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ST_RUN = 2'b00,
        ST_WFI = 2'b01,
        ST_ERR = 2'b10,
        ST_TMO = 2'b11
    } status_t;

endpackage

// File: rtl/core_sim_irq_ch.sv
// core_sim_irq_ch: one scheduled external interrupt channel.
// Fires once per run when cycle_cnt matches start. Pulse mode holds the line
// for `width` cycles; level mode holds it until ack is sampled high.
// Ports:
//   clk, rst   - clock, async active-high reset
//   run        - controller is in RUN
//   end_now    - an end condition is being taken this cycle
//   cycle_cnt  - run cycle counter
//   start      - fire cycle
//   width      - pulse width (0 disables the channel)
//   ack        - level-mode acknowledge
//   irq        - registered interrupt line
module core_sim_irq_ch #(
    parameter int CNT_W     = 16,
    parameter int WID_W     = 8,
    parameter bit IRQ_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             end_now,
    input  logic [CNT_W-1:0] cycle_cnt,
    input  logic [CNT_W-1:0] start,
    input  logic [WID_W-1:0] width,
    input  logic             ack,
    output logic             irq
);

    logic             fired;
    logic [WID_W-1:0] remain;
    logic             fire;

    assign fire = run && !fired && (width != '0) && (cycle_cnt == start);

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // blocking assignments would make the result depend on evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fired  <= 1'b0;
            remain <= '0;
            irq    <= 1'b0;
        end else begin
            // The fired flag is never cleared outside reset, so a wrap of
            // cycle_cnt cannot re-trigger the channel.
            if (fire)
                fired <= 1'b1;

            // Ending the run wins over a fire in the same cycle.
            if (!run || end_now) begin
                irq <= 1'b0;
            end else if (fire) begin
                irq    <= 1'b1;
                remain <= width;
            end else if (irq) begin
                if (IRQ_LEVEL) begin
                    if (ack)
                        irq <= 1'b0;
                end else if (remain == WID_W'(1)) begin
                    irq <= 1'b0;
                end else begin
                    remain <= remain - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/core_sim_ctrl.sv
// core_sim_ctrl: simulation / bring-up controller for core_top.
// Holds the core in reset for RST_CYCLES after rst, then runs, schedules
// N_IRQ interrupt events, and ends the run on error, WFI streak or timeout
// with a sticky status.
// Ports:
//   clk, rst          - clock, async active-high reset
//   irq_start         - per-channel fire cycle, slice [i*CNT_W +: CNT_W]
//   irq_width         - per-channel pulse width, slice [i*WID_W +: WID_W]
//   irq_ack           - per-channel level-mode acknowledge
//   core_wfi          - core waiting for interrupt
//   core_unexcp_err   - core unexpected error
//   core_rst_n        - registered active-low core reset
//   pc_init_use       - PC_INIT_USE once reset is released
//   ext_irq           - registered interrupt lines
//   cycle_cnt         - run cycles elapsed
//   sim_done          - sticky end-of-run
//   sim_status        - 00 running, 01 WFI, 10 error, 11 timeout
module core_sim_ctrl
    import core_sim_pkg::*;
#(
    parameter int N_IRQ       = 1,
    parameter int CNT_W       = 16,
    parameter int WID_W       = 8,
    parameter int RST_CYCLES  = 8,
    parameter int WFI_CYCLES  = 4,
    parameter int TIMEOUT     = 100,
    parameter bit IRQ_LEVEL   = 1'b0,
    parameter bit PC_INIT_USE = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_IRQ*CNT_W-1:0] irq_start,
    input  logic [N_IRQ*WID_W-1:0] irq_width,
    input  logic [N_IRQ-1:0]       irq_ack,
    input  logic                   core_wfi,
    input  logic                   core_unexcp_err,
    output logic                   core_rst_n,
    output logic                   pc_init_use,
    output logic [N_IRQ-1:0]       ext_irq,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic                   sim_done,
    output logic [1:0]             sim_status
);

    // Counters only need to reach N-1; keep at least one bit.
    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int WFI_W  = (WFI_CYCLES > 1) ? $clog2(WFI_CYCLES) : 1;

    state_t            state, state_nxt;
    status_t           end_code;
    logic [HOLD_W-1:0] hold_cnt;
    logic [WFI_W-1:0]  wfi_cnt;
    logic              run;
    logic              hold_done;
    logic              wfi_hit;
    logic              tmo_hit;
    logic              end_now;

    assign run       = (state == S_RUN);
    assign hold_done = (hold_cnt == HOLD_W'(RST_CYCLES - 1));
    // wfi_cnt counts previous consecutive high cycles; the current one completes the streak.
    assign wfi_hit   = core_wfi && (wfi_cnt == WFI_W'(WFI_CYCLES - 1));
    assign tmo_hit   = (cycle_cnt == CNT_W'(TIMEOUT - 1));
    assign end_now   = run && (core_unexcp_err || wfi_hit || tmo_hit);

    // NOTE: every combinational output gets a default before the branches,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        end_code = ST_TMO;
        if (core_unexcp_err)
            end_code = ST_ERR;
        else if (wfi_hit)
            end_code = ST_WFI;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HOLD:  if (hold_done) state_nxt = S_RUN;
            S_RUN:   if (end_now)   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_HOLD;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt    <= '0;
            wfi_cnt     <= '0;
            cycle_cnt   <= '0;
            core_rst_n  <= 1'b0;
            pc_init_use <= 1'b0;
            sim_done    <= 1'b0;
            sim_status  <= ST_RUN;
        end else begin
            if (state == S_HOLD)
                hold_cnt <= hold_cnt + 1'b1;

            // Counts every RUN cycle, including the one that ends the run;
            // frozen from DONE onward.
            if (run)
                cycle_cnt <= cycle_cnt + 1'b1;

            wfi_cnt <= (run && core_wfi && !wfi_hit) ? wfi_cnt + 1'b1 : '0;

            // Registered off the next state so release lands exactly on the
            // RST_CYCLES-th edge.
            core_rst_n  <= (state_nxt != S_HOLD);
            pc_init_use <= (state_nxt != S_HOLD) ? PC_INIT_USE : 1'b0;

            if (end_now) begin
                sim_done   <= 1'b1;
                sim_status <= end_code;
            end
        end
    end

    for (genvar i = 0; i < N_IRQ; i++) begin : g_ch
        core_sim_irq_ch #(
            .CNT_W     (CNT_W),
            .WID_W     (WID_W),
            .IRQ_LEVEL (IRQ_LEVEL)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .run       (run),
            .end_now   (end_now),
            .cycle_cnt (cycle_cnt),
            .start     (irq_start[i*CNT_W +: CNT_W]),
            .width     (irq_width[i*WID_W +: WID_W]),
            .ack       (irq_ack[i]),
            .irq       (ext_irq[i])
        );
    end

endmodule

// File: tb/tb_core_sim_ctrl.sv
// tb_core_sim_ctrl: directed bench for core_sim_ctrl.
// Two instances share clock, reset and core status inputs: a two-channel
// pulse-mode controller (PC_INIT_USE=1) and a one-channel level-mode one.
// Cycle numbers below refer to cycle_cnt: cycle c is the period after the
// (8+c)-th rising edge following rst release.
module tb_core_sim_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_wfi;
    logic        core_err;

    logic [31:0] p_start;
    logic [15:0] p_width;
    logic [1:0]  p_ack;
    logic        p_rst_n, p_pc, p_done;
    logic [1:0]  p_irq, p_status;
    logic [15:0] p_cnt;

    logic [15:0] l_start;
    logic [7:0]  l_width;
    logic        l_ack;
    logic        l_rst_n, l_pc, l_done, l_irq;
    logic [1:0]  l_status;
    logic [15:0] l_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    core_sim_ctrl #(.N_IRQ(2), .IRQ_LEVEL(1'b0), .PC_INIT_USE(1'b1)) u_pulse (
        .clk             (clk),
        .rst             (rst),
        .irq_start       (p_start),
        .irq_width       (p_width),
        .irq_ack         (p_ack),
        .core_wfi        (core_wfi),
        .core_unexcp_err (core_err),
        .core_rst_n      (p_rst_n),
        .pc_init_use     (p_pc),
        .ext_irq         (p_irq),
        .cycle_cnt       (p_cnt),
        .sim_done        (p_done),
        .sim_status      (p_status)
    );

    core_sim_ctrl #(.N_IRQ(1), .IRQ_LEVEL(1'b1), .PC_INIT_USE(1'b0)) u_level (
        .clk             (clk),
        .rst             (rst),
        .irq_start       (l_start),
        .irq_width       (l_width),
        .irq_ack         (l_ack),
        .core_wfi        (core_wfi),
        .core_unexcp_err (core_err),
        .core_rst_n      (l_rst_n),
        .pc_init_use     (l_pc),
        .ext_irq         (l_irq),
        .cycle_cnt       (l_cnt),
        .sim_done        (l_done),
        .sim_status      (l_status)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset, release, and advance to cycle 0 of the run.
    task automatic start_run();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(8);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        core_wfi = 1'b0;
        core_err = 1'b0;
        p_start  = '0;
        p_width  = '0;
        p_ack    = '0;
        l_start  = '0;
        l_width  = '0;
        l_ack    = 1'b0;
        step(1);
        n_tests++;
        if ({p_rst_n, p_pc, p_irq, p_cnt, p_done, p_status} !== 23'h0) begin
            n_fail++;
            $display("FAIL reset_pulse: got %h expected 0",
                     {p_rst_n, p_pc, p_irq, p_cnt, p_done, p_status});
        end
        n_tests++;
        if ({l_rst_n, l_pc, l_irq, l_cnt, l_done, l_status} !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_level: got %h expected 0",
                     {l_rst_n, l_pc, l_irq, l_cnt, l_done, l_status});
        end
    endtask

    task automatic test_release_timeout();
        logic exp;
        p_width = '0;
        l_width = '0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            exp = (k == 8);
            n_tests++;
            if (p_rst_n !== exp) begin
                n_fail++;
                $display("FAIL rst_n_edge%0d: got %b expected %b", k, p_rst_n, exp);
            end
        end
        n_tests++;
        if ({p_pc, l_pc} !== 2'b10) begin
            n_fail++;
            $display("FAIL pc_init_use: got %b expected 10", {p_pc, l_pc});
        end
        n_tests++;
        if (p_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL cnt_first_run: got %0d expected 0", p_cnt);
        end
        step(99);
        n_tests++;
        if ({p_done, p_cnt} !== {1'b0, 16'd99}) begin
            n_fail++;
            $display("FAIL cnt_99: got done=%b cnt=%0d expected done=0 cnt=99", p_done, p_cnt);
        end
        step(1);
        n_tests++;
        if ({p_done, p_status, p_cnt} !== {1'b1, 2'b11, 16'd100}) begin
            n_fail++;
            $display("FAIL timeout_done: got done=%b st=%b cnt=%0d expected done=1 st=11 cnt=100",
                     p_done, p_status, p_cnt);
        end
        step(5);
        n_tests++;
        if ({p_done, p_status, p_cnt, p_rst_n} !== {1'b1, 2'b11, 16'd100, 1'b1}) begin
            n_fail++;
            $display("FAIL done_sticky: got done=%b st=%b cnt=%0d rst_n=%b expected 1 11 100 1",
                     p_done, p_status, p_cnt, p_rst_n);
        end
    endtask

    task automatic test_pulse();
        logic [1:0] exp;
        p_start = {16'd10, 16'd10};
        p_width = {8'd0, 8'd3};
        start_run();
        for (int c = 0; c <= 20; c++) begin
            p_ack = (c == 12) ? 2'b01 : 2'b00;
            exp   = (c >= 11 && c <= 13) ? 2'b01 : 2'b00;
            n_tests++;
            if (p_irq !== exp) begin
                n_fail++;
                $display("FAIL pulse_c%0d: got %b expected %b", c, p_irq, exp);
            end
            step(1);
        end
        p_ack = 2'b00;
    endtask

    task automatic test_level();
        logic exp;
        l_start = 16'd5;
        l_width = 8'd1;
        start_run();
        for (int c = 0; c <= 30; c++) begin
            l_ack = (c == 3 || c == 20 || c == 25);
            exp   = (c >= 6 && c <= 20);
            n_tests++;
            if (l_irq !== exp) begin
                n_fail++;
                $display("FAIL level_c%0d: got %b expected %b", c, l_irq, exp);
            end
            step(1);
        end
        l_ack   = 1'b0;
        l_width = '0;
    endtask

    // WFI streak broken at 39, completed 40..43. The error variant adds
    // core_unexcp_err at 43 and an IRQ scheduled to fire in that same cycle.
    task automatic test_wfi(input bit with_err);
        logic [1:0] exp_st;
        logic [1:0] exp_irq;
        p_start = with_err ? {16'd0, 16'd43} : {16'd0, 16'd42};
        p_width = {8'd0, 8'd5};
        exp_st  = with_err ? 2'b10 : 2'b01;
        exp_irq = with_err ? 2'b00 : 2'b01;
        start_run();
        for (int c = 0; c <= 43; c++) begin
            core_wfi = (c >= 36 && c != 39);
            core_err = (with_err && c == 43);
            if (c >= 36) begin
                n_tests++;
                if (p_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wfi%0d_early_done_c%0d: got %b expected 0", with_err, c, p_done);
                end
            end
            if (c == 43) begin
                n_tests++;
                if (p_irq !== exp_irq) begin
                    n_fail++;
                    $display("FAIL wfi%0d_irq_c43: got %b expected %b", with_err, p_irq, exp_irq);
                end
            end
            step(1);
        end
        core_wfi = 1'b0;
        core_err = 1'b0;
        n_tests++;
        if ({p_done, p_status, p_cnt, p_irq} !== {1'b1, exp_st, 16'd44, 2'b00}) begin
            n_fail++;
            $display("FAIL wfi%0d_end: got done=%b st=%b cnt=%0d irq=%b expected 1 %b 44 00",
                     with_err, p_done, p_status, p_cnt, p_irq, exp_st);
        end
        step(3);
        n_tests++;
        if ({p_done, p_status, p_irq} !== {1'b1, exp_st, 2'b00}) begin
            n_fail++;
            $display("FAIL wfi%0d_hold: got done=%b st=%b irq=%b expected 1 %b 00",
                     with_err, p_done, p_status, p_irq, exp_st);
        end
    endtask

    task automatic test_rst_mid_pulse();
        p_start = {16'd0, 16'd10};
        p_width = {8'd0, 8'd3};
        start_run();
        step(12);
        n_tests++;
        if (p_irq !== 2'b01) begin
            n_fail++;
            $display("FAIL midpulse_irq: got %b expected 01", p_irq);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({p_rst_n, p_pc, p_irq, p_cnt, p_done, p_status} !== 23'h0) begin
            n_fail++;
            $display("FAIL async_rst: got %h expected 0",
                     {p_rst_n, p_pc, p_irq, p_cnt, p_done, p_status});
        end
        start_run();
        step(10);
        n_tests++;
        if (p_irq !== 2'b00) begin
            n_fail++;
            $display("FAIL refire_c10: got %b expected 00", p_irq);
        end
        step(1);
        n_tests++;
        if (p_irq !== 2'b01) begin
            n_fail++;
            $display("FAIL refire_c11: got %b expected 01", p_irq);
        end
    endtask

    initial begin
        test_reset();
        test_release_timeout();
        test_pulse();
        test_level();
        test_wfi(1'b0);
        test_wfi(1'b1);
        test_rst_mid_pulse();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core_sim_ctrl.md
# core_sim_ctrl

Parametrised simulation/bring-up controller that sits between the bench clock/reset source and `core_top`. It sequences core reset release and drives `pc_init_use`. It schedules up to `N_IRQ` external interrupt events, in pulse or level mode, and decides end-of-run from WFI, unexpected error or watchdog timeout. It reports a sticky status, so benches and FPGA smoke tests no longer hard-code delays and `$finish` times.

## Interface
Parameters:
- `N_IRQ`, 1: number of external interrupt channels.
- `CNT_W`, 16: width of run-cycle counter and per-channel start times.
- `WID_W`, 8: width of per-channel pulse width.
- `RST_CYCLES`, 8: cycles the core is held in reset after `rst` deasserts (≥1).
- `WFI_CYCLES`, 4: consecutive `core_wfi` cycles that end the run (≥1).
- `TIMEOUT`, 100: run cycles before watchdog expiry (≤ 2^CNT_W−1).
- `IRQ_LEVEL`, 0: 0 selects pulse mode; 1 selects level mode (held until ack).
- `PC_INIT_USE`, 0: value driven on `pc_init_use` once reset is released.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `irq_start`, in, N_IRQ*CNT_W: channel i start cycle in slice [i*CNT_W +: CNT_W]. Must be static while running.
- `irq_width`, in, N_IRQ*WID_W: channel i pulse width. 0 disables the channel.
- `irq_ack`, in, N_IRQ: level-mode acknowledge per channel.
- `core_wfi`, in, 1: from core.
- `core_unexcp_err`, in, 1: from core.
- `core_rst_n`, out, 1: core reset, active-low, registered.
- `pc_init_use`, out, 1: to core.
- `ext_irq`, out, N_IRQ: external interrupts to core, registered.
- `cycle_cnt`, out, CNT_W: run cycles elapsed.
- `sim_done`, out, 1: sticky end-of-run.
- `sim_status`, out, 2: 00 running, 01 WFI, 10 error, 11 timeout.

## Operation
- FSM states: HOLD, RUN, DONE. Reset enters HOLD.
- HOLD:
  - Hold counter increments each cycle.
  - On the cycle the counter reaches `RST_CYCLES`−1, go to RUN.
  - Outputs: `core_rst_n`=0, `pc_init_use`=0, `ext_irq`=0.
- RUN:
  - `core_rst_n`=1 and `pc_init_use`=`PC_INIT_USE`.
  - `cycle_cnt` is 0 in the first RUN cycle and then increments each cycle.
- Channel i, width ≠ 0, one-shot per run:
  - Fires when `cycle_cnt` == start_i.
  - Pulse mode: `ext_irq[i]` high for exactly width_i cycles.
  - Level mode: `ext_irq[i]` high until `irq_ack[i]` is sampled high; width value is ignored.
  - A channel already fired never re-fires, including when `cycle_cnt` wraps.
  - `irq_ack` has no effect in pulse mode or when the line is low.
- End conditions, evaluated in RUN each cycle, priority error > WFI > timeout:
  - Error: `core_unexcp_err` high.
  - WFI: `core_wfi` high for `WFI_CYCLES` consecutive cycles. Any low cycle clears the streak.
  - Timeout: `cycle_cnt` == `TIMEOUT`−1.
- DONE:
  - `sim_done`=1 and `sim_status` latched.
  - `ext_irq` forced 0, `cycle_cnt` frozen, `core_rst_n` stays 1.
  - DONE exits only on `rst`.
- `rst` asserted in any state immediately returns all registers to reset values, including mid-pulse and mid-WFI-streak.

## Timing
- Reset values: `core_rst_n`=0, `pc_init_use`=0, `ext_irq`=0, `cycle_cnt`=0, `sim_done`=0, `sim_status`=00.
- `core_rst_n` rises on the `RST_CYCLES`-th rising edge after `rst` deasserts.
- IRQ latency: `ext_irq[i]` rises on the edge after the cycle where `cycle_cnt`==start_i.
- Level-mode ack: `ext_irq[i]` falls on the edge after ack is sampled.
- End latency: `sim_done` and `sim_status` are set on the edge after the triggering cycle. In the same edge `ext_irq` clears.
- Simultaneous events: an IRQ fire and an end condition in the same cycle resolve to DONE, and the IRQ never asserts.

## Structure
- Shared package `core_sim_pkg`: FSM state encodings and `sim_status` codes (`ST_RUN`, `ST_WFI`, `ST_ERR`, `ST_TMO`).
- Sub-module `core_sim_irq_ch`: one channel (fired flag, width counter, level/ack logic), generated `N_IRQ` times.
- Top holds the FSM, hold counter, `cycle_cnt`, WFI streak counter and end arbitration.

## Test plan
- `RST_CYCLES`=8, no IRQ, core idle -> `core_rst_n` rises 8 edges after `rst` falls; timeout at `cycle_cnt`=99, `sim_status`=11.
- Pulse mode, N_IRQ=2, starts 10 and 10, widths 3 and 0 -> `ext_irq`=01 for cycles 11–13 only; channel 1 is never asserted.
- Level mode, start 5, ack at cycle 20 -> `ext_irq[0]` high edges 6–20, low from 21; a second ack has no effect.
- `core_wfi` high for 3 cycles, low 1, then high 4 from cycle 40 -> done at cycle 44 with status 01. Same stimulus with `core_unexcp_err` at cycle 43 -> status 10.
- `rst` asserted mid-pulse at cycle 12 -> all outputs return to reset values immediately. After re-release the channel fires again at start.
